// File: rtl/adc_ring_writer.sv
// ADC sample ring writer: buffers incoming samples in a small FIFO and streams them
// into a circular word region of memory through a req/busy handshake.
module adc_ring_writer #(
  parameter logic [25:0] BASE_ADDR  = 26'h0000000,
  parameter int unsigned RING_WORDS = 1048576,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          sample_valid,
  input  logic [31:0]                   sample_data,
  input  logic                          ptr_clear,
  input  logic                          clear_overflow,
  output logic                          memory_read_req,
  output logic                          memory_write_req,
  output logic [25:0]                   memory_addr,
  output logic [31:0]                   memory_data_write,
  input  logic                          memory_busy,
  output logic [25:0]                   wr_offset,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [15:0]                   drop_count
);

  localparam int unsigned AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [25:0]   OFF_LAST = 26'(RING_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [25:0]     offset_q, offset_d;
  logic            clr_pend_q, clr_pend_d;
  logic            req_q, req_d;
  logic [25:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drop_q, drop_d;
  logic [31:0]     mem_q [FIFO_DEPTH];

  logic            full_c;
  logic            push_c;
  logic            drop_c;
  logic            pop_c;

  // Next-state, FIFO bookkeeping and registered output values
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    offset_d   = offset_q;
    clr_pend_d = clr_pend_q;
    req_d      = req_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ovf_d      = ovf_q;
    drop_d     = drop_q;
    pop_c      = 1'b0;

    // Full is judged on the registered level, so a same-cycle pop never frees room
    full_c = (level_q == LVL_FULL);
    push_c = enable && sample_valid && !full_c;
    drop_c = enable && sample_valid && full_c;

    case (state_q)
      IDLE: begin
        if (ptr_clear) begin
          offset_d = 26'd0;
        end
        if ((level_q != '0) && !memory_busy) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = BASE_ADDR + (ptr_clear ? 26'd0 : offset_q);
          data_d  = mem_q[rd_ptr_q];
        end
      end
      REQ: begin
        if (ptr_clear) begin
          clr_pend_d = 1'b1;
        end
        if (memory_busy) begin
          state_d = WAIT_DONE;
          req_d   = 1'b0;
        end
      end
      WAIT_DONE: begin
        if (ptr_clear) begin
          clr_pend_d = 1'b1;
        end
        if (!memory_busy) begin
          pop_c      = 1'b1;
          state_d    = IDLE;
          clr_pend_d = 1'b0;
          // A pending clear supersedes the advance for the word just completed
          if (clr_pend_q || ptr_clear) begin
            offset_d = 26'd0;
          end else if (offset_q == OFF_LAST) begin
            offset_d = 26'd0;
          end else begin
            offset_d = offset_q + 26'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as clear_overflow restarts the count at one
    if (drop_c) begin
      ovf_d = 1'b1;
      if (clear_overflow) begin
        drop_d = 16'd1;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end else if (clear_overflow) begin
      ovf_d  = 1'b0;
      drop_d = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      offset_q   <= 26'd0;
      clr_pend_q <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= 26'd0;
      data_q     <= 32'd0;
      ovf_q      <= 1'b0;
      drop_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      offset_q   <= offset_d;
      clr_pend_q <= clr_pend_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end

  // Sample storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= sample_data;
    end
  end

  assign memory_read_req   = 1'b0;
  assign memory_write_req  = req_q;
  assign memory_addr       = addr_q;
  assign memory_data_write = data_q;
  assign wr_offset         = offset_q;
  assign fifo_level        = level_q;
  assign overflow          = ovf_q;
  assign drop_count        = drop_q;

endmodule

// File: doc/adc_ring_writer.md
ADC_RING_WRITER -- requirements
Module: adc_ring_writer

Interface
REQ-001 Parameter BASE_ADDR, default 26'h0000000, first word address of the ring in memory.
REQ-002 Parameter RING_WORDS, default 1048576, ring length in 32-bit words (2..2^26).
REQ-003 Parameter FIFO_DEPTH, default 16, sample FIFO entries (power of two).
REQ-004 clk  in  1  system clock, all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  accept samples while high.
REQ-007 sample_valid  in  1  one-cycle strobe, sample_data valid.
REQ-008 sample_data  in  32  packed ADC word.
REQ-009 ptr_clear  in  1  request ring offset return to 0.
REQ-010 clear_overflow  in  1  clears sticky overflow.
REQ-011 memory_read_req  out  1  constant 0.
REQ-012 memory_write_req  out  1  write request to the memory interface.
REQ-013 memory_addr  out  26  word address of the pending write.
REQ-014 memory_data_write  out  32  data of the pending write.
REQ-015 memory_busy  in  1  memory interface accepted/executing a request.
REQ-016 wr_offset  out  26  next ring offset to be written.
REQ-017 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-018 overflow  out  1  sticky: at least one sample dropped.
REQ-019 drop_count  out  16  dropped samples, saturating at 16'hFFFF.

Function
REQ-020 Push: when enable=1, sample_valid=1 and fifo_level<FIFO_DEPTH, sample_data SHALL be written to the FIFO and fifo_level SHALL increment on that edge.
REQ-021 Drop: when enable=1, sample_valid=1 and fifo_level=FIFO_DEPTH, the sample SHALL be discarded, overflow SHALL be set, and drop_count SHALL increment unless it is 16'hFFFF.
REQ-022 Full is judged on the registered level; a pop in the same cycle does not free space for that push.
REQ-023 Simultaneous push and pop on a non-full FIFO SHALL leave fifo_level unchanged.
REQ-024 sample_valid with enable=0 SHALL be ignored without a drop count; enable=0 does not stop draining.
REQ-025 FSM states IDLE, REQ, WAIT_DONE.
REQ-026 IDLE->REQ when fifo_level>0 and memory_busy=0. memory_addr=BASE_ADDR+wr_offset and memory_data_write=FIFO head are latched on this edge.
REQ-027 In REQ, memory_write_req SHALL be 1; addr/data SHALL be held stable; REQ->WAIT_DONE on the first cycle memory_busy=1.
REQ-028 In WAIT_DONE, memory_write_req SHALL be 0; on memory_busy=0 the FIFO head SHALL be popped, wr_offset advanced, and the FSM SHALL return to IDLE.
REQ-029 Minimum cost per word is 3 cycles with a single-cycle memory_busy.
REQ-030 wr_offset SHALL advance by 1 and wrap from RING_WORDS-1 to 0.
REQ-031 ptr_clear SHALL set wr_offset to 0 only in IDLE. If ptr_clear arrives outside IDLE it SHALL be held pending and applied on the return to IDLE, superseding that advance.
REQ-032 clear_overflow SHALL zero overflow and drop_count. A simultaneous drop SHALL win: overflow=1 and drop_count=1.
REQ-033 memory_write_req SHALL never assert while memory_busy=1 in IDLE.

Reset
REQ-034 On reset=0, asynchronously: FSM=IDLE, memory_write_req=0, memory_read_req=0, memory_addr=0, memory_data_write=0, wr_offset=0, fifo_level=0, overflow=0, drop_count=0, and the pending ptr_clear is cleared.
REQ-035 Reset during REQ or WAIT_DONE SHALL abandon the transfer. The word is lost, and the next write after release uses offset 0.

Verification
REQ-036 Single write. Stimulus: sample 32'hDEADBEEF; memory_busy high for 1 cycle after the request. Response: one request, memory_addr=BASE_ADDR, data=32'hDEADBEEF, wr_offset=1, fifo_level=0.
REQ-037 Backpressure. Stimulus: memory_busy held 0 after the request; 20 samples pushed. Response: memory_write_req stays 1 with stable addr/data; fifo_level=16; overflow=1; drop_count=4.
REQ-038 Wrap. Stimulus: RING_WORDS=4; 6 writes. Response: addresses are BASE+0,1,2,3,0,1; final wr_offset=2.
REQ-039 ptr_clear mid-transfer. Stimulus: ptr_clear pulsed in WAIT_DONE at offset 5. Response: wr_offset=0 after completion; the next write goes to BASE_ADDR.
REQ-040 clear_overflow colliding with a drop. Stimulus: clear_overflow and a drop in the same cycle. Response: overflow=1, drop_count=1.
REQ-041 Reset in REQ. Stimulus: reset=0 while in REQ. Response: memory_write_req=0 immediately; all outputs at REQ-034 values.
